// File: rtl/timer_peripheral.sv
// Memory-mapped prescaled down-counter with one-shot/auto-reload modes,
// W1C status flags and a registered level interrupt.
module timer_peripheral #(
  parameter logic [31:0] BASE_ADDR = 32'h810,
  parameter int          CNT_W     = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WEtimer,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        irq
);

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_LOAD   = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  genvar gi;

  // Address decode
  logic [32:0] adr_ext;
  logic        hit;
  logic [1:0]  offset;
  logic        wr_ctrl;
  logic        wr_load;
  logic        wr_status;

  assign adr_ext   = {1'b0, DataAdr};
  assign hit       = (adr_ext >= {1'b0, BASE_ADDR}) &&
                     (adr_ext <= ({1'b0, BASE_ADDR} + 33'hF));
  assign offset    = DataAdr[3:2];
  assign wr_ctrl   = WEtimer && hit && (offset == OFF_CTRL);
  assign wr_load   = WEtimer && hit && (offset == OFF_LOAD);
  assign wr_status = WEtimer && hit && (offset == OFF_STATUS);

  // Register state
  logic             en_reg,     en_next;
  logic             auto_reg,   auto_next;
  logic             irq_en_reg, irq_en_next;
  logic [7:0]       presc_reg,  presc_next;
  logic [7:0]       pc_reg,     pc_next;
  logic [CNT_W-1:0] load_reg,   load_next;
  logic [CNT_W-1:0] count_reg,  count_next;
  logic [1:0]       status_reg, status_next;
  logic             irq_reg,    irq_next;

  logic             tick;
  logic             expiry;
  logic [1:0]       status_set;
  logic [1:0]       status_clr;
  logic             unused_wd;

  assign unused_wd = ^WriteData;

  // A tick is a function of pre-edge state; CTRL/LOAD writes only affect what follows
  assign tick   = en_reg && (pc_reg == presc_reg);
  assign expiry = tick && (count_reg == '0);

  always_comb begin
    pc_next = pc_reg;
    if (wr_ctrl || wr_load) begin
      pc_next = '0;
    end else if (!en_reg || tick) begin
      pc_next = '0;
    end else begin
      pc_next = pc_reg + 8'd1;
    end
  end

  always_comb begin
    en_next     = en_reg;
    auto_next   = auto_reg;
    irq_en_next = irq_en_reg;
    presc_next  = presc_reg;
    if (expiry && !auto_reg) begin
      en_next = 1'b0;
    end
    if (wr_ctrl) begin
      en_next     = WriteData[0];
      auto_next   = WriteData[1];
      irq_en_next = WriteData[2];
      presc_next  = WriteData[15:8];
    end
  end

  always_comb begin
    load_next  = load_reg;
    count_next = count_reg;
    if (tick) begin
      if (count_reg != '0) begin
        count_next = count_reg - CNT_W'(1);
      end else if (auto_reg) begin
        count_next = load_reg;
      end else begin
        count_next = '0;
      end
    end
    if (wr_load) begin
      load_next  = WriteData[CNT_W-1:0];
      count_next = WriteData[CNT_W-1:0];
    end
  end

  // Bit 0 = EXP, bit 1 = OVF; a same-cycle set beats the W1C clear
  assign status_set = {expiry & status_reg[0], expiry};
  assign status_clr = wr_status ? WriteData[1:0] : 2'b00;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_status
      assign status_next[gi] = (status_reg[gi] & ~status_clr[gi]) | status_set[gi];
    end
  endgenerate

  assign irq_next = status_next[0] & irq_en_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      en_reg     <= 1'b0;
      auto_reg   <= 1'b0;
      irq_en_reg <= 1'b0;
      presc_reg  <= '0;
      pc_reg     <= '0;
      load_reg   <= '0;
      count_reg  <= '0;
      status_reg <= '0;
      irq_reg    <= 1'b0;
    end else begin
      en_reg     <= en_next;
      auto_reg   <= auto_next;
      irq_en_reg <= irq_en_next;
      presc_reg  <= presc_next;
      pc_reg     <= pc_next;
      load_reg   <= load_next;
      count_reg  <= count_next;
      status_reg <= status_next;
      irq_reg    <= irq_next;
    end
  end

  assign irq = irq_reg;

  always_comb begin
    ReadData = '0;
    if (hit) begin
      case (offset)
        OFF_CTRL:  ReadData = {16'h0, presc_reg, 5'h0, irq_en_reg, auto_reg, en_reg};
        OFF_LOAD:  ReadData = 32'(load_reg);
        OFF_COUNT: ReadData = 32'(count_reg);
        default:   ReadData = {30'h0, status_reg};
      endcase
    end
  end

endmodule

// File: tb/tb_timer_peripheral.sv
// Self-checking bench for timer_peripheral: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a reference model.
module tb_timer_peripheral;

  localparam logic [31:0] BASE = 32'h810;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        WEtimer = 1'b0;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] last_rd;
  logic        last_irq;

  timer_peripheral #(.BASE_ADDR(BASE), .CNT_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .WEtimer   (WEtimer),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Reference model state, kept as plain fields of the programmer-visible registers
  bit          m_valid = 0;
  bit          m_en, m_auto, m_irq_en, m_exp, m_ovf, m_irq;
  int unsigned m_presc, m_pc;
  logic [31:0] m_load, m_count;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h expected=%08h", name, got, exp);
    end
  endtask

  function automatic bit in_window(input logic [31:0] a);
    return (a >= BASE) && (a <= BASE + 32'hF);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (!in_window(a)) return 32'h0;
    case (a[3:2])
      2'd0:    return (m_presc << 8) | (32'(m_irq_en) << 2) | (32'(m_auto) << 1) | 32'(m_en);
      2'd1:    return m_load;
      2'd2:    return m_count;
      default: return (32'(m_ovf) << 1) | 32'(m_exp);
    endcase
  endfunction

  function automatic bit m_expiry_pending();
    return m_en && (m_pc == m_presc) && (m_count == 0);
  endfunction

  // One clock edge of the timer, described as "count, then let writes override"
  task automatic model_step();
    bit tick, expire, was_exp, was_en;
    if (reset) begin
      {m_en, m_auto, m_irq_en, m_exp, m_ovf, m_irq} = '0;
      m_presc = 0; m_pc = 0; m_load = 0; m_count = 0;
      m_valid = 1;
      return;
    end
    was_exp = m_exp;
    was_en  = m_en;
    tick    = m_en && (m_pc == m_presc);
    expire  = tick && (m_count == 0);
    m_pc    = (was_en && !tick) ? (m_pc + 1) % 256 : 0;
    if (tick) begin
      if (m_count > 0) begin
        m_count = m_count - 1;
      end else begin
        m_exp = 1;
        if (was_exp) m_ovf = 1;
        if (m_auto) m_count = m_load;
        else        m_en = 0;
      end
    end
    if (WEtimer && in_window(DataAdr)) begin
      case (DataAdr[3:2])
        2'd0: begin
          m_en = WriteData[0]; m_auto = WriteData[1]; m_irq_en = WriteData[2];
          m_presc = int'(WriteData[15:8]); m_pc = 0;
        end
        2'd1: begin
          m_load = WriteData; m_count = WriteData; m_pc = 0;
        end
        2'd3: begin
          if (WriteData[0] && !expire) m_exp = 0;
          if (WriteData[1] && !(expire && was_exp)) m_ovf = 0;
        end
        default: ;
      endcase
    end
    m_irq = m_exp && m_irq_en;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison of both outputs against the model
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("rdata_model", ReadData, m_read(DataAdr));
      check("irq_model", 32'(irq), 32'(m_irq));
    end
  end

  task automatic cyc(input logic rst, input logic we, input logic [31:0] adr,
                     input logic [31:0] wd, input string tag);
    reset = rst; WEtimer = we; DataAdr = adr; WriteData = wd;
    @(negedge clk);
    last_rd  = ReadData;
    last_irq = irq;
    $display("txn %-8s rst=%b we=%b adr=%08h wd=%08h rd=%08h irq=%b",
             tag, rst, we, adr, wd, last_rd, last_irq);
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] wd);
    cyc(1'b0, 1'b1, adr, wd, "write");
  endtask

  task automatic rd_lit(input logic [31:0] adr, input logic [31:0] exp, input string name);
    cyc(1'b0, 1'b0, adr, 32'h0, "read");
    check(name, last_rd, exp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    #1;
    // 1: reset and reads
    cyc(1'b1, 1'b0, BASE, 32'h0, "reset");
    cyc(1'b1, 1'b0, BASE, 32'h0, "reset");
    rd_lit(32'h810, 32'h0, "rst_ctrl");
    check("rst_irq", 32'(last_irq), 32'h0);
    rd_lit(32'h814, 32'h0, "rst_load");
    rd_lit(32'h818, 32'h0, "rst_count");
    rd_lit(32'h81C, 32'h0, "rst_status");
    rd_lit(32'h7FC, 32'h0, "miss_low");
    rd_lit(32'h820, 32'h0, "miss_high");

    // 2: one-shot
    wr(32'h814, 32'd3);
    wr(32'h810, 32'h005);
    for (int i = 0; i < 4; i++) rd_lit(32'h818, 32'(3 - i), "oneshot_count");
    rd_lit(32'h810, 32'h004, "oneshot_ctrl");
    check("oneshot_irq", 32'(last_irq), 32'h1);
    rd_lit(32'h81C, 32'h1, "oneshot_status");
    for (int i = 0; i < 10; i++) rd_lit(32'h818, 32'h0, "oneshot_hold");

    // 3: auto-reload with prescaler
    wr(32'h81C, 32'h3);
    wr(32'h814, 32'd2);
    wr(32'h810, 32'h0403);
    for (int k = 0; k < 30; k++) rd_lit(32'h818, 32'(2 - (k % 15) / 5), "auto_count");
    rd_lit(32'h81C, 32'h3, "auto_ovf");

    // 4: W1C and collision
    wr(32'h810, 32'h0407);
    rd_lit(32'h81C, 32'h3, "w1c_pre");
    check("w1c_irq_pre", 32'(last_irq), 32'h1);
    wr(32'h81C, 32'h1);
    rd_lit(32'h81C, 32'h2, "w1c_post");
    check("w1c_irq_post", 32'(last_irq), 32'h0);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_expiry_pending()) begin
        wr(32'h81C, 32'h1);
        found = 1;
      end else begin
        cyc(1'b0, 1'b0, 32'h818, 32'h0, "wait");
      end
    end
    check("collision_found", 32'(found), 32'h1);
    rd_lit(32'h81C, 32'h3, "collision_set_wins");
    check("collision_irq", 32'(last_irq), 32'h1);

    // 5: LOAD write beats a same-cycle decrement
    wr(32'h814, 32'd10);
    wr(32'h810, 32'h003);
    for (int i = 0; i < 5; i++) rd_lit(32'h818, 32'(10 - i), "prio_count");
    wr(32'h814, 32'h100);
    rd_lit(32'h818, 32'h100, "prio_load_wins");
    rd_lit(32'h818, 32'h0FF, "prio_resume");

    // 6: decode isolation and mid-run reset
    wr(32'h80C, 32'hFFFF_FFFF);
    rd_lit(32'h814, 32'h100, "iso_miss_write");
    cyc(1'b0, 1'b0, 32'h814, 32'h55, "nowe");
    rd_lit(32'h814, 32'h100, "iso_no_we");
    cyc(1'b1, 1'b1, 32'h814, 32'd7, "rst_wr");
    rd_lit(32'h810, 32'h0, "midrst_ctrl");
    rd_lit(32'h814, 32'h0, "midrst_load");
    rd_lit(32'h818, 32'h0, "midrst_count");
    rd_lit(32'h81C, 32'h0, "midrst_status");
    check("midrst_irq", 32'(last_irq), 32'h0);

    // Randomized traffic, checked every cycle by the model comparator
    for (int n = 0; n < 3000; n++) begin
      int unsigned sel;
      logic [31:0] a, d;
      logic        we, rst;
      sel = $urandom_range(0, 9);
      if (sel <= 7)      a = BASE + 32'($urandom_range(0, 15));
      else if (sel == 8) a = ($urandom_range(0, 1) == 0) ? 32'h80C : 32'h820;
      else               a = $urandom;
      we = ($urandom_range(0, 4) == 0);
      d  = $urandom;
      if (a[3:2] == 2'd0) begin
        d[15:8] = 8'($urandom_range(0, 3));
        if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
      end
      if (a[3:2] == 2'd1 && $urandom_range(0, 3) != 0) d = 32'($urandom_range(0, 6));
      rst = ($urandom_range(0, 299) == 0);
      cyc(rst, we, a, d, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
